alu_mc: RTL and testbench

Parametrised multi-cycle ALU that succeeds the fixed 16-bit combinational ALU in the custom processor datapath. It adds subtract, XOR, shifts and an iterative shift-add multiply, and produces carry and zero flags. Operands enter through a valid/ready handshake and results leave through one. Only one operation is in flight at a time. It sits between the register-read stage and write-back, so the control unit stalls on `in_ready`/`out_valid` instead of assuming one-cycle results.

---
 rtl/alu_mc_if.sv | 27 ++
 rtl/alu_mc.sv | 126 ++++++++++++
 tb/tb_alu_mc.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_mc_if.sv
// rtl/alu_mc_if.sv - operand/result handshake bundle for alu_mc
//   in_valid/in_ready/op/in1/in2 : operation request (master -> slave)
//   out_valid/out_ready/out/carry/zero : result (slave -> master)
interface alu_mc_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             carry;
    logic             zero;

    modport master (
        output in_valid, op, in1, in2, out_ready,
        input  in_ready, out_valid, out, carry, zero
    );

    modport slave (
        input  in_valid, op, in1, in2, out_ready,
        output in_ready, out_valid, out, carry, zero
    );
endinterface

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with shift-add multiply and carry/zero flags
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : alu_mc_if.slave (request in, result out)
module alu_mc #(
    parameter int WIDTH = 16
) (
    input  logic     clk,
    input  logic     rst,
    alu_mc_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] acc_step;

    // Extra MSB on sum/diff holds carry-out / borrow.
    assign sum      = {1'b0, bus.in1} + {1'b0, bus.in2};
    assign diff     = {1'b0, bus.in1} - {1'b0, bus.in2};
    assign shamt    = bus.in2[SHW-1:0];
    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        carry_d  = carry_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.op == 3'b111) begin
                        mcand_d  = bus.in1;
                        mplier_d = bus.in2;
                        acc_d    = '0;
                        cnt_d    = CW'(WIDTH);
                        state_d  = MUL;
                    end else begin
                        carry_d = 1'b0;
                        state_d = DONE;
                        case (bus.op)
                            3'b000: begin
                                out_d   = sum[WIDTH-1:0];
                                carry_d = sum[WIDTH];
                            end
                            3'b001: begin
                                out_d   = diff[WIDTH-1:0];
                                carry_d = diff[WIDTH];
                            end
                            3'b010:  out_d = bus.in1 & bus.in2;
                            3'b011:  out_d = bus.in1 | bus.in2;
                            3'b100:  out_d = bus.in1 ^ bus.in2;
                            3'b101:  out_d = bus.in1 << shamt;
                            3'b110:  out_d = bus.in1 >> shamt;
                            default: out_d = '0;
                        endcase
                    end
                end
            end
            MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                // Last step: publish the accumulator including this step's add.
                if (cnt_q == CW'(1)) begin
                    out_d   = acc_step;
                    carry_d = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            out_q    <= '0;
            carry_q  <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            carry_q  <= carry_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    // Handshake outputs come from registered state only.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out       = out_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = (out_q == '0);
endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - directed self-checking bench for alu_mc
module tb_alu_mc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    alu_mc_if #(.WIDTH(16)) bus ();

    alu_mc #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Issue one op and wait (bounded) for out_valid; lat = 1 when valid right after the accept edge.
    task automatic run_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                          output int lat, output logic [15:0] r, output logic c,
                          output logic z, output logic rdy_low);
        bus.op       = o;
        bus.in1      = a;
        bus.in2      = b;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat     = 1;
        rdy_low = 1'b1;
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready) rdy_low = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (bus.in_ready) rdy_low = 1'b0;
        r = bus.out;
        c = bus.carry;
        z = bus.zero;
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset in_ready: got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out !== 16'h0000) begin n_err++; $display("FAIL reset out: got %h want 0000", bus.out); end
        n_cmp++; if (bus.carry !== 1'b0) begin n_err++; $display("FAIL reset carry: got %b want 0", bus.carry); end
        n_cmp++; if (bus.zero !== 1'b1) begin n_err++; $display("FAIL reset zero: got %b want 1", bus.zero); end
    endtask

    task automatic test_add_wrap();
        int lat; logic [15:0] r; logic c, z, rl;
        run_op(3'b000, 16'hFFFF, 16'h0001, lat, r, c, z, rl);
        n_cmp++; if (r !== 16'h0000) begin n_err++; $display("FAIL add_wrap out: got %h want 0000", r); end
        n_cmp++; if (c !== 1'b1) begin n_err++; $display("FAIL add_wrap carry: got %b want 1", c); end
        n_cmp++; if (z !== 1'b1) begin n_err++; $display("FAIL add_wrap zero: got %b want 1", z); end
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL add_wrap latency: got %0d want 1", lat); end
        release_out();
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL add_wrap in_ready after release: got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL add_wrap out_valid after release: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_sub();
        int lat; logic [15:0] r; logic c, z, rl;
        run_op(3'b001, 16'h0003, 16'h0005, lat, r, c, z, rl);
        n_cmp++; if (r !== 16'hFFFE) begin n_err++; $display("FAIL sub_borrow out: got %h want fffe", r); end
        n_cmp++; if (c !== 1'b1) begin n_err++; $display("FAIL sub_borrow carry: got %b want 1", c); end
        n_cmp++; if (z !== 1'b0) begin n_err++; $display("FAIL sub_borrow zero: got %b want 0", z); end
        release_out();
        run_op(3'b001, 16'h0005, 16'h0003, lat, r, c, z, rl);
        n_cmp++; if (r !== 16'h0002) begin n_err++; $display("FAIL sub_plain out: got %h want 0002", r); end
        n_cmp++; if (c !== 1'b0) begin n_err++; $display("FAIL sub_plain carry: got %b want 0", c); end
        release_out();
    endtask

    task automatic test_logic();
        int lat; logic [15:0] r; logic c, z, rl;
        run_op(3'b010, 16'hF0F0, 16'h3C3C, lat, r, c, z, rl);
        n_cmp++; if (r !== 16'h3030) begin n_err++; $display("FAIL and out: got %h want 3030", r); end
        release_out();
        run_op(3'b011, 16'hF0F0, 16'h3C3C, lat, r, c, z, rl);
        n_cmp++; if (r !== 16'hFCFC) begin n_err++; $display("FAIL or out: got %h want fcfc", r); end
        n_cmp++; if (c !== 1'b0) begin n_err++; $display("FAIL or carry: got %b want 0", c); end
        release_out();
        run_op(3'b100, 16'hA5A5, 16'hA5A5, lat, r, c, z, rl);
        n_cmp++; if (r !== 16'h0000) begin n_err++; $display("FAIL xor out: got %h want 0000", r); end
        n_cmp++; if (z !== 1'b1) begin n_err++; $display("FAIL xor zero: got %b want 1", z); end
        release_out();
    endtask

    task automatic test_shift();
        int lat; logic [15:0] r; logic c, z, rl;
        run_op(3'b101, 16'h0001, 16'h0013, lat, r, c, z, rl);
        n_cmp++; if (r !== 16'h0008) begin n_err++; $display("FAIL shl_mask out: got %h want 0008", r); end
        release_out();
        run_op(3'b110, 16'h8000, 16'h000F, lat, r, c, z, rl);
        n_cmp++; if (r !== 16'h0001) begin n_err++; $display("FAIL shr_max out: got %h want 0001", r); end
        release_out();
        run_op(3'b101, 16'h8001, 16'h0001, lat, r, c, z, rl);
        n_cmp++; if (r !== 16'h0002) begin n_err++; $display("FAIL shl_drop out: got %h want 0002", r); end
        n_cmp++; if (c !== 1'b0) begin n_err++; $display("FAIL shl_drop carry: got %b want 0", c); end
        release_out();
    endtask

    task automatic test_mul();
        int lat; logic [15:0] r; logic c, z, rl;
        run_op(3'b111, 16'h0123, 16'h0011, lat, r, c, z, rl);
        n_cmp++; if (r !== 16'h1353) begin n_err++; $display("FAIL mul_basic out: got %h want 1353", r); end
        n_cmp++; if (c !== 1'b0) begin n_err++; $display("FAIL mul_basic carry: got %b want 0", c); end
        n_cmp++; if (lat !== 17) begin n_err++; $display("FAIL mul_basic latency: got %0d want 17", lat); end
        n_cmp++; if (rl !== 1'b1) begin n_err++; $display("FAIL mul_basic in_ready low: got %b want 1", rl); end
        release_out();
        run_op(3'b111, 16'hFFFF, 16'hFFFF, lat, r, c, z, rl);
        n_cmp++; if (r !== 16'h0001) begin n_err++; $display("FAIL mul_trunc out: got %h want 0001", r); end
        release_out();
        run_op(3'b111, 16'h1234, 16'h0000, lat, r, c, z, rl);
        n_cmp++; if (r !== 16'h0000) begin n_err++; $display("FAIL mul_zero out: got %h want 0000", r); end
        n_cmp++; if (z !== 1'b1) begin n_err++; $display("FAIL mul_zero zero: got %b want 1", z); end
        release_out();
        run_op(3'b111, 16'h00FF, 16'h0101, lat, r, c, z, rl);
        n_cmp++; if (r !== 16'hFFFF) begin n_err++; $display("FAIL mul_ff out: got %h want ffff", r); end
        release_out();
    endtask

    task automatic test_backpressure();
        int lat; logic [15:0] r; logic c, z, rl;
        run_op(3'b000, 16'h0010, 16'h0020, lat, r, c, z, rl);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = (i == 2);
            bus.op  = 3'b000;
            bus.in1 = 16'h0001;
            bus.in2 = 16'h0001;
            n_cmp++; if (bus.out !== 16'h0030) begin n_err++; $display("FAIL bp out cyc%0d: got %h want 0030", i, bus.out); end
            n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp out_valid cyc%0d: got %b want 1", i, bus.out_valid); end
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp in_ready cyc%0d: got %b want 0", i, bus.in_ready); end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out !== 16'h0030) begin n_err++; $display("FAIL bp out held: got %h want 0030", bus.out); end
        release_out();
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp in_ready after release: got %b want 1", bus.in_ready); end
        @(posedge clk); #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp stray capture out_valid: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid_mul();
        int lat; logic [15:0] r; logic c, z, rl;
        bus.op = 3'b111; bus.in1 = 16'h1234; bus.in2 = 16'h5678; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL rstmul busy in_ready: got %b want 0", bus.in_ready); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rstmul out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rstmul in_ready: got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.out !== 16'h0000) begin n_err++; $display("FAIL rstmul out: got %h want 0000", bus.out); end
        run_op(3'b000, 16'h0002, 16'h0003, lat, r, c, z, rl);
        n_cmp++; if (r !== 16'h0005) begin n_err++; $display("FAIL rstmul add out: got %h want 0005", r); end
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL rstmul add latency: got %0d want 1", lat); end
        release_out();
    endtask

    task automatic test_back_to_back();
        int lat; logic [15:0] r; logic c, z, rl;
        bus.out_ready = 1'b1;
        run_op(3'b000, 16'h1000, 16'h0234, lat, r, c, z, rl);
        n_cmp++; if (r !== 16'h1234) begin n_err++; $display("FAIL b2b first out: got %h want 1234", r); end
        @(posedge clk); #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b in_ready: got %b want 1", bus.in_ready); end
        run_op(3'b001, 16'h0000, 16'h0001, lat, r, c, z, rl);
        n_cmp++; if (r !== 16'hFFFF) begin n_err++; $display("FAIL b2b second out: got %h want ffff", r); end
        n_cmp++; if (c !== 1'b1) begin n_err++; $display("FAIL b2b second carry: got %b want 1", c); end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL b2b drained out_valid: got %b want 0", bus.out_valid); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op        = 3'b000;
        bus.in1       = 16'h0000;
        bus.in2       = 16'h0000;
        test_reset();
        test_add_wrap();
        test_sub();
        test_logic();
        test_shift();
        test_mul();
        test_backpressure();
        test_reset_mid_mul();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
